// File: rtl/traffic_phase_scheduler_pkg.sv
// ============================================================================
// traffic_pkg : lamp codes, phase encoding and lamp-code helper shared by the
//               traffic phase scheduler.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

  localparam logic [2:0] GREEN  = 3'b101;
  localparam logic [2:0] YELLOW = 3'b001;
  localparam logic [2:0] RED    = 3'b011;

  // Members carry a PH_ prefix so they do not collide with the lamp codes.
  typedef enum logic [1:0] {
    PH_GREEN   = 2'd0,
    PH_YELLOW  = 2'd1,
    PH_ALL_RED = 2'd2
  } phase_e;

  function automatic logic [2:0] lamp_code(input logic [1:0] ph, input logic granted);
    logic [2:0] code;
    code = RED;
    if (granted) begin
      if (ph == PH_GREEN)
        code = GREEN;
      else if (ph == PH_YELLOW)
        code = YELLOW;
    end
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_phase_scheduler_if.sv
// ============================================================================
// traffic_phase_scheduler_if : sensor requests in, lamp/grant/phase/tick out.
// Revision                   : 1.0  initial release
// ============================================================================
`default_nettype none

interface traffic_phase_scheduler_if #(
  parameter int N_APPR = 4
);
  logic [N_APPR-1:0]   req;
  logic [3*N_APPR-1:0] light;
  logic [N_APPR-1:0]   grant;
  logic [1:0]          phase;
  logic                tick;

  modport master (output req, input light, grant, phase, tick);
  modport slave  (input req, output light, grant, phase, tick);
endinterface

`default_nettype wire

// File: rtl/traffic_phase_scheduler_tick_prescaler.sv
// ============================================================================
// tick_prescaler : free-running 0..TICK_DIV-1 counter with registered strobe
//                  high in the cycle the count sits at TICK_DIV-1.
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int         W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;

  assign cnt_nxt = (cnt == LAST) ? '0 : cnt + W'(1);

  // Strobe is registered from the next count so it lines up with cnt==LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= (TICK_DIV == 1);
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == LAST);
    end
  end

endmodule

`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
// ============================================================================
// traffic_phase_scheduler : round-robin right-of-way scheduler with min/max
//   green, yellow and all-red clearance. Optional emergency preemption is
//   enabled by defining TRAFFIC_PREEMPT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int N_APPR    = 4,
  parameter int TICK_DIV  = 50000000,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 5
) (
  input  logic                       clk,
  input  logic                       reset,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic                       preempt_req,
  input  logic [$clog2(N_APPR)-1:0]  preempt_sel,
`endif
  traffic_phase_scheduler_if.slave   bus
);

  localparam int IDX_W = $clog2(N_APPR);
  localparam logic [1:0] S_GREEN   = PH_GREEN;
  localparam logic [1:0] S_YELLOW  = PH_YELLOW;
  localparam logic [1:0] S_ALL_RED = PH_ALL_RED;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] MIN_G   = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_G   = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] YEL_T   = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] AR_T    = CNT_W'(ALLRED_T);

  logic                tick;
  logic [1:0]          phase, phase_nxt;
  logic [IDX_W-1:0]    cur, cur_nxt, rr_pick, pre_sel;
  logic [CNT_W-1:0]    elapsed, elapsed_nxt;
  logic [N_APPR-1:0]   grant;
  logic [3*N_APPR-1:0] light, light_nxt;
  logic                others, pre_valid, pre_hold, pre_other;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign others = |(bus.req & ~grant);

`ifdef TRAFFIC_PREEMPT_EN
  assign pre_valid = preempt_req && (int'(preempt_sel) < N_APPR);
  assign pre_sel   = preempt_sel;
`else
  assign pre_valid = 1'b0;
  assign pre_sel   = '0;
`endif
  assign pre_hold  = pre_valid && (pre_sel == cur);
  assign pre_other = pre_valid && (pre_sel != cur);

  // Rotating search cur+1, cur+2, ...; falls back to cur when nobody waits.
  always_comb begin
    int  idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    rr_pick = cur;
    for (int k = 1; k <= N_APPR; k++) begin
      idx = (int'(cur) + k) % N_APPR;
      if (!found && bus.req[idx]) begin
        rr_pick = IDX_W'(idx);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    phase_nxt = phase;
    cur_nxt   = cur;
    case (phase)
      S_GREEN: begin
        if (pre_other ||
            (!pre_hold && elapsed >= MIN_G && others &&
             (!bus.req[cur] || elapsed >= MAX_G)))
          phase_nxt = S_YELLOW;
      end
      S_YELLOW: begin
        if (elapsed >= YEL_T)
          phase_nxt = S_ALL_RED;
      end
      S_ALL_RED: begin
        if (elapsed >= AR_T) begin
          phase_nxt = S_GREEN;
          cur_nxt   = pre_valid ? pre_sel : rr_pick;
        end
      end
      default: phase_nxt = S_GREEN;
    endcase
  end

  always_comb begin
    elapsed_nxt = elapsed;
    if (phase_nxt != phase)
      elapsed_nxt = '0;
    else if (tick && elapsed != CNT_SAT)
      elapsed_nxt = elapsed + CNT_W'(1);
  end

  always_comb begin
    light_nxt = '0;
    for (int i = 0; i < N_APPR; i++)
      light_nxt[3*i +: 3] = lamp_code(phase_nxt, cur_nxt == IDX_W'(i));
  end

  // Lamps and grant are registered from the next-state values so they
  // change on the same edge as the phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase   <= S_GREEN;
      cur     <= '0;
      elapsed <= '0;
      grant   <= N_APPR'(1);
      light   <= {{(N_APPR-1){RED}}, GREEN};
    end else begin
      phase   <= phase_nxt;
      cur     <= cur_nxt;
      elapsed <= elapsed_nxt;
      grant   <= N_APPR'(1) << cur_nxt;
      light   <= light_nxt;
    end
  end

  assign bus.light = light;
  assign bus.grant = grant;
  assign bus.phase = phase;
  assign bus.tick  = tick;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
// ============================================================================
// tb_traffic_phase_scheduler : directed bench, TICK_DIV=4 MIN=3 MAX=6 Y=2 AR=1.
// Revision                   : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_traffic_phase_scheduler;

  localparam logic [11:0] L_RESET = 12'b011_011_011_101;
  localparam logic [11:0] L_Y0    = 12'b011_011_011_001;
  localparam logic [11:0] L_AR    = 12'b011_011_011_011;
  localparam logic [11:0] L_G1    = 12'b011_011_101_011;
  localparam logic [11:0] L_G2    = 12'b011_101_011_011;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cyc;

`ifdef TRAFFIC_PREEMPT_EN
  logic       preempt_req;
  logic [1:0] preempt_sel;
`endif

  traffic_phase_scheduler_if #(.N_APPR(4)) bus ();

  traffic_phase_scheduler #(
    .N_APPR(4), .TICK_DIV(4), .MIN_GREEN(3), .MAX_GREEN(6),
    .YELLOW_T(2), .ALLRED_T(1), .CNT_W(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef TRAFFIC_PREEMPT_EN
    .preempt_req (preempt_req),
    .preempt_sel (preempt_sel),
`endif
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Never more than one non-RED lamp.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      int nr;
      nr = 0;
      for (int i = 0; i < 4; i++)
        if (bus.light[3*i +: 3] !== 3'b011) nr++;
      total++;
      if (nr > 1) begin
        bad++;
        $display("FAIL lamp_safety: light=%b has %0d non-red lamps, required <=1", bus.light, nr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic [3:0] r);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    bus.req = r;
    cyc     = 0;
  endtask

  task automatic wait_phase(input logic [1:0] p, input int budget, output bit ok);
    int n;
    n = 0;
    while (bus.phase !== p && n < budget) begin
      step();
      n++;
    end
    ok = (bus.phase === p);
  endtask

  task automatic test_reset();
    do_reset(4'b0000);
    total++;
    if (bus.grant !== 4'b0001 || bus.phase !== 2'd0 || bus.light !== L_RESET || bus.tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: grant=%b phase=%0d light=%b tick=%b, required 0001/0/%b/0",
               bus.grant, bus.phase, bus.light, bus.tick, L_RESET);
    end
    for (int k = 0; k < 200; k++) begin
      step();
      total++;
      if (bus.grant !== 4'b0001 || bus.phase !== 2'd0 || bus.light !== L_RESET) begin
        bad++;
        $display("FAIL idle_hold: cyc=%0d grant=%b phase=%0d light=%b, required 0001/0/%b",
                 cyc, bus.grant, bus.phase, bus.light, L_RESET);
      end
      total++;
      if (bus.tick !== (cyc % 4 == 3)) begin
        bad++;
        $display("FAIL tick_period: cyc=%0d tick=%b, required %b", cyc, bus.tick, (cyc % 4 == 3));
      end
    end
  endtask

  task automatic test_single_request();
    logic [1:0]  ep;
    logic [11:0] el;
    do_reset(4'b0100);
    for (int k = 0; k < 25; k++) begin
      step();
      if (cyc <= 12)      begin ep = 2'd0; el = L_RESET; end
      else if (cyc <= 20) begin ep = 2'd1; el = L_Y0;    end
      else if (cyc <= 24) begin ep = 2'd2; el = L_AR;    end
      else                begin ep = 2'd0; el = L_G2;    end
      total++;
      if (bus.phase !== ep || bus.light !== el) begin
        bad++;
        $display("FAIL single_req_seq: cyc=%0d phase=%0d light=%b, required %0d/%b",
                 cyc, bus.phase, bus.light, ep, el);
      end
    end
    total++;
    if (bus.grant !== 4'b0100) begin
      bad++;
      $display("FAIL single_req_grant: grant=%b, required 0100", bus.grant);
    end
  endtask

  task automatic test_round_robin_max();
    logic [3:0] exp_g [4];
    bit ok;
    int ticks;
    int n;
    exp_g[0] = 4'b0010; exp_g[1] = 4'b0100; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
    do_reset(4'b1111);
    while (cyc < 25) step();
    total++;
    if (bus.phase !== 2'd1) begin
      bad++;
      $display("FAIL max_green_first: cyc=25 phase=%0d, required 1", bus.phase);
    end
    for (int g = 0; g < 4; g++) begin
      wait_phase(2'd0, 100, ok);
      total++;
      if (!ok || bus.grant !== exp_g[g]) begin
        bad++;
        $display("FAIL rr_grant: entry=%0d grant=%b ok=%0d, required %b", g, bus.grant, ok, exp_g[g]);
      end
      ticks = 0;
      n = 0;
      while (bus.phase === 2'd0 && n < 100) begin
        if (bus.tick === 1'b1) ticks++;
        step();
        n++;
      end
      total++;
      if (ticks != 6) begin
        bad++;
        $display("FAIL green_length: entry=%0d ticks=%0d, required 6", g, ticks);
      end
    end
  endtask

  task automatic test_wrap_regrant();
    bit ok;
    do_reset(4'b1000);
    while (cyc < 13) step();
    total++;
    if (bus.phase !== 2'd1) begin
      bad++;
      $display("FAIL min_green_exit: cyc=13 phase=%0d, required 1", bus.phase);
    end
    wait_phase(2'd0, 50, ok);
    total++;
    if (!ok || bus.grant !== 4'b1000) begin
      bad++;
      $display("FAIL grant_cur3: grant=%b ok=%0d, required 1000", bus.grant, ok);
    end
    bus.req = 4'b1010;
    wait_phase(2'd2, 100, ok);
    wait_phase(2'd0, 50, ok);
    total++;
    if (!ok || bus.grant !== 4'b0010 || bus.light !== L_G1) begin
      bad++;
      $display("FAIL wrap_grant: grant=%b light=%b ok=%0d, required 0010/%b", bus.grant, bus.light, ok, L_G1);
    end
    wait_phase(2'd2, 100, ok);
    bus.req = 4'b0000;
    wait_phase(2'd0, 50, ok);
    total++;
    if (!ok || bus.grant !== 4'b0010) begin
      bad++;
      $display("FAIL regrant_cur: grant=%b ok=%0d, required 0010", bus.grant, ok);
    end
    repeat (50) step();
    total++;
    if (bus.phase !== 2'd0 || bus.grant !== 4'b0010) begin
      bad++;
      $display("FAIL rest_green: phase=%0d grant=%b, required 0/0010", bus.phase, bus.grant);
    end
  endtask

  task automatic test_reset_mid_phase();
    do_reset(4'b0100);
    while (cyc < 15) step();
    total++;
    if (bus.phase !== 2'd1) begin
      bad++;
      $display("FAIL pre_reset_yellow: phase=%0d, required 1", bus.phase);
    end
    reset = 1'b1;
    step();
    total++;
    if (bus.grant !== 4'b0001 || bus.phase !== 2'd0 || bus.light !== L_RESET || bus.tick !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: grant=%b phase=%0d light=%b tick=%b, required 0001/0/%b/0",
               bus.grant, bus.phase, bus.light, bus.tick, L_RESET);
    end
    reset = 1'b0;
    cyc   = 0;
    while (cyc < 12) step();
    total++;
    if (bus.phase !== 2'd0) begin
      bad++;
      $display("FAIL timer_cleared: cyc=12 phase=%0d, required 0", bus.phase);
    end
    step();
    total++;
    if (bus.phase !== 2'd1) begin
      bad++;
      $display("FAIL timer_restart: cyc=13 phase=%0d, required 1", bus.phase);
    end
  endtask

`ifdef TRAFFIC_PREEMPT_EN
  task automatic test_preempt();
    bit ok;
    do_reset(4'b0000);
    while (cyc < 4) step();
    preempt_sel = 2'd2;
    preempt_req = 1'b1;
    step();
    total++;
    if (bus.phase !== 2'd1 || bus.grant !== 4'b0001) begin
      bad++;
      $display("FAIL preempt_yellow: phase=%0d grant=%b, required 1/0001", bus.phase, bus.grant);
    end
    wait_phase(2'd0, 50, ok);
    total++;
    if (!ok || bus.grant !== 4'b0100) begin
      bad++;
      $display("FAIL preempt_grant: grant=%b ok=%0d, required 0100", bus.grant, ok);
    end
    bus.req = 4'b1111;
    repeat (80) begin
      step();
      total++;
      if (bus.phase !== 2'd0 || bus.grant !== 4'b0100) begin
        bad++;
        $display("FAIL preempt_hold: cyc=%0d phase=%0d grant=%b, required 0/0100", cyc, bus.phase, bus.grant);
      end
    end
    preempt_req = 1'b0;
    wait_phase(2'd1, 10, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL preempt_release: phase=%0d, required 1", bus.phase);
    end
    bus.req = 4'b0000;
  endtask
`endif

  initial begin
    total   = 0;
    bad     = 0;
    cyc     = 0;
    reset   = 1'b1;
    bus.req = 4'b0000;
`ifdef TRAFFIC_PREEMPT_EN
    preempt_req = 1'b0;
    preempt_sel = 2'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_request();
    test_round_robin_max();
    test_wrap_regrant();
    test_reset_mid_phase();
`ifdef TRAFFIC_PREEMPT_EN
    test_preempt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
